// File: rtl/mcol_serial_ctrl_pkg.sv
// Shared constants, FSM state type and element indexing for the Fides-160
// serial MixColumns datapath.
package fides_pkg;

    localparam int W    = 5;
    localparam int NROW = 4;
    localparam int NCOL = 8;
    localparam int SW   = NROW * NCOL * W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mcol_state_t;

    // Element e = 4*c + r sits at bits [W*e +: W] of a state share.
    function automatic int idx(input int c, input int r);
        return NROW * c + r;
    endfunction

endpackage

// File: rtl/mcol_serial_ctrl_if.sv
// Handshake and data bus between a share producer/consumer (master) and the
// serial MixColumns sequencer (slave).
interface mcol_serial_ctrl_if;
    import fides_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          busy;
    logic          flush;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/mcol_serial_ctrl_mcolrow.sv
// One MixColumns output element: XOR of the three other elements of its column.
module mcolrow
    import fides_pkg::*;
(
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    output logic [W-1:0] y
);

    assign y = a1 ^ a2 ^ a3;

endmodule

// File: rtl/mcol_serial_ctrl.sv
// Serial MixColumns sequencer for one share: walks the state column by column,
// row by row, through a single time-shared mcolrow instance.
module mcol_serial_ctrl
    import fides_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mcol_serial_ctrl_if.slave  bus
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

    mcol_state_t   state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [1:0]    row, row_nxt;
    logic [SW-1:0] in_buf;
    logic [SW-1:0] out_data;
    logic          load;
    logic          write_en;
    logic [W-1:0]  col_e [NROW];
    logic [W-1:0]  a1, a2, a3, y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            in_buf   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            if (load) begin
                in_buf <= bus.in_data;
            end
            if (write_en) begin
                out_data[W*idx(int'(col), int'(row)) +: W] <= y;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        load      = 1'b0;
        write_en  = 1'b0;
        if (bus.flush) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        load      = 1'b1;
                        col_nxt   = '0;
                        row_nxt   = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    write_en = 1'b1;
                    if (row == 2'd3) begin
                        row_nxt = '0;
                        if (col == CW'(NCOL - 1)) begin
                            col_nxt   = '0;
                            state_nxt = DONE;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand mux: the three rows other than the current one, ascending order.
    always_comb begin
        for (int r = 0; r < NROW; r++) begin
            col_e[r] = in_buf[W*idx(int'(col), r) +: W];
        end
        a1 = col_e[1];
        a2 = col_e[2];
        a3 = col_e[3];
        case (row)
            2'd0: begin a1 = col_e[1]; a2 = col_e[2]; a3 = col_e[3]; end
            2'd1: begin a1 = col_e[0]; a2 = col_e[2]; a3 = col_e[3]; end
            2'd2: begin a1 = col_e[0]; a2 = col_e[1]; a3 = col_e[3]; end
            default: begin a1 = col_e[0]; a2 = col_e[1]; a3 = col_e[2]; end
        endcase
    end

    mcolrow u_mcolrow (
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .y  (y)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_mcol_serial_ctrl.sv
// Self-checking bench for mcol_serial_ctrl: vector table, random shares against a
// column-parity reference model, and hand-written reset/flush/backpressure sequences.
module tb_mcol_serial_ctrl;
    import fides_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mcol_serial_ctrl_if bus();

    mcol_serial_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [SW-1:0] din;
        logic [SW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference: each element = (XOR of whole column) ^ (own element).
    function automatic logic [SW-1:0] mix(input logic [SW-1:0] s);
        logic [SW-1:0] o;
        logic [W-1:0]  colx;
        o = '0;
        for (int c = 0; c < NCOL; c++) begin
            colx = '0;
            for (int r = 0; r < NROW; r++) colx ^= s[W*(4*c+r) +: W];
            for (int r = 0; r < NROW; r++) o[W*(4*c+r) +: W] = colx ^ s[W*(4*c+r) +: W];
        end
        return o;
    endfunction

    function automatic logic [SW-1:0] rand_share();
        logic [SW-1:0] s;
        for (int i = 0; i < SW/32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    // The accepting edge is clock 1; out_valid must appear 32 edges later (clock 33).
    task automatic run_share(input string name, input logic [SW-1:0] din,
                             input logic [SW-1:0] exp, output logic [SW-1:0] dout);
        int n;
        chk({name, " in_ready_idle"}, SW'(bus.in_ready), SW'(1));
        bus.in_data  = din;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({name, " busy_run"}, SW'(bus.busy), SW'(1));
        wait_done(n);
        chk({name, " latency"}, SW'(n), SW'(32));
        dout = bus.out_data;
        chk({name, " out_data"}, dout, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({name, " out_valid_drop"}, SW'(bus.out_valid), SW'(0));
        chk({name, " in_ready_back"}, SW'(bus.in_ready), SW'(1));
        chk({name, " out_data_kept"}, bus.out_data, dout);
    endtask

    initial begin
        logic [SW-1:0] din, exp, got, a, b, oa, ob, oab, snap;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        #12 rst_n = 1'b1;
        step();
        chk("rst in_ready", SW'(bus.in_ready), SW'(1));
        chk("rst out_valid", SW'(bus.out_valid), SW'(0));
        chk("rst busy", SW'(bus.busy), SW'(0));
        chk("rst out_data", bus.out_data, '0);

        // Vector table: directed patterns with hand-computed results, then random shares.
        din = '0;
        din[W*0 +: W] = 5'h01; din[W*1 +: W] = 5'h02;
        din[W*2 +: W] = 5'h04; din[W*3 +: W] = 5'h08;
        exp = '0;
        exp[W*0 +: W] = 5'h0E; exp[W*1 +: W] = 5'h0D;
        exp[W*2 +: W] = 5'h0B; exp[W*3 +: W] = 5'h07;
        vecs.push_back('{"col0_onehot", din, exp});
        vecs.push_back('{"all_1f", {SW{1'b1}}, {SW{1'b1}}});
        vecs.push_back('{"all_00", {SW{1'b0}}, {SW{1'b0}}});
        for (int i = 0; i < 6; i++) begin
            din = rand_share();
            vecs.push_back('{$sformatf("rand%0d", i), din, mix(din)});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            run_share(vecs[i].name, vecs[i].din, vecs[i].exp, got);
        end

        // Linearity of two random shares.
        a = rand_share();
        b = rand_share();
        run_share("lin_a", a, mix(a), oa);
        run_share("lin_b", b, mix(b), ob);
        run_share("lin_ab", a ^ b, mix(a ^ b), oab);
        chk("linearity", oa ^ ob, oab);

        // Backpressure in DONE with a competing in_valid.
        din = rand_share();
        bus.in_data  = din;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_done(n);
        chk("bp latency", SW'(n), SW'(32));
        snap = bus.out_data;
        chk("bp out_data", snap, mix(din));
        bus.in_data  = rand_share();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp hold%0d out_data", i), bus.out_data, snap);
            chk($sformatf("bp hold%0d out_valid", i), SW'(bus.out_valid), SW'(1));
            chk($sformatf("bp hold%0d in_ready", i), SW'(bus.in_ready), SW'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp release", SW'(bus.out_valid), SW'(0));

        // Asynchronous reset in RUN cycle 12.
        bus.in_data  = rand_share();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", SW'(bus.out_valid), SW'(0));
        chk("arst busy", SW'(bus.busy), SW'(0));
        chk("arst in_ready", SW'(bus.in_ready), SW'(1));
        chk("arst out_data", bus.out_data, '0);
        step();
        rst_n = 1'b1;
        step();
        din = rand_share();
        run_share("after_rst", din, mix(din), got);

        // Flush in RUN cycle 12, held into IDLE with in_valid high.
        bus.in_data  = rand_share();
        bus.in_valid = 1'b1;
        step();
        for (int i = 0; i < 11; i++) step();
        bus.flush = 1'b1;
        step();
        chk("flush busy", SW'(bus.busy), SW'(0));
        chk("flush in_ready", SW'(bus.in_ready), SW'(1));
        chk("flush out_valid", SW'(bus.out_valid), SW'(0));
        step();
        chk("flush blocks accept", SW'(bus.busy), SW'(0));
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        din = rand_share();
        run_share("after_flush", din, mix(din), got);

        // Back-to-back with out_ready tied high.
        a = rand_share();
        b = rand_share();
        bus.out_ready = 1'b1;
        bus.in_data   = a;
        bus.in_valid  = 1'b1;
        step();
        bus.in_data = b;
        wait_done(n);
        chk("b2b first latency", SW'(n), SW'(32));
        chk("b2b first data", bus.out_data, mix(a));
        step();
        chk("b2b idle in_ready", SW'(bus.in_ready), SW'(1));
        step();
        chk("b2b second accepted", SW'(bus.busy), SW'(1));
        bus.in_valid = 1'b0;
        wait_done(n);
        chk("b2b second latency", SW'(n), SW'(32));
        chk("b2b second data", bus.out_data, mix(b));
        step();
        bus.out_ready = 1'b0;
        chk("b2b end idle", SW'(bus.in_ready), SW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
